// File: rtl/ulv_shift_pkg.sv
// Shared types for the shift/rotate register: operation encodings and serial FSM states.
package ulv_shift_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_SRA  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_LOAD = 3'b110,
    OP_SER  = 3'b111
  } shift_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/ulv_barrel_shifter.sv
// Combinational barrel shifter/rotator; ops that do not shift pass data through unchanged.
module ulv_barrel_shifter
  import ulv_shift_pkg::*;
#(
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic [N-1:0]  data,
  input  logic [AW-1:0] amt,
  input  shift_op_e     op,
  input  logic          si,
  output logic [N-1:0]  result
);

  logic [2*N-1:0] ext;

  // Shifting a double-width vector gives fill/rotate bits for free; amt=0 is identity.
  always_comb begin
    ext    = '0;
    result = data;
    case (op)
      OP_SHL: begin
        ext    = {data, {N{si}}} << amt;
        result = ext[2*N-1:N];
      end
      OP_SHR: begin
        ext    = {{N{si}}, data} >> amt;
        result = ext[N-1:0];
      end
      OP_SRA: begin
        ext    = {{N{data[N-1]}}, data} >> amt;
        result = ext[N-1:0];
      end
      OP_ROL: begin
        ext    = {data, data} << amt;
        result = ext[2*N-1:N];
      end
      OP_ROR: begin
        ext    = {data, data} >> amt;
        result = ext[N-1:0];
      end
      default: result = data;
    endcase
  end

endmodule

// File: rtl/ulv_shift_rot_reg.sv
// N-bit shift/rotate register with parallel load and a serial-transmit FSM (N >= 2).
module ulv_shift_rot_reg
  import ulv_shift_pkg::*;
#(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic          si,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          so,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ser_state_e    state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  shift_op_e     op_e;
  logic [N-1:0]  shift_res;
  logic [N-1:0]  ser_next;

  assign op_e = shift_op_e'(op);

  ulv_barrel_shifter #(.N(N)) u_shifter (
    .data   (q_q),
    .amt    (amt),
    .op     (op_e),
    .si     (si),
    .result (shift_res)
  );

  // Serial shift moves bits toward the so end and fills the far end with si.
  assign ser_next = (MSB_FIRST != 0) ? {q_q[N-2:0], si} : {si, q_q[N-1:1]};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (op_e == OP_SER) begin
            q_d     = d;
            cnt_d   = CNT_LOAD;
            state_d = ST_SHIFT;
          end else if (op_e == OP_LOAD) begin
            q_d = d;
          end else begin
            q_d = shift_res;
          end
        end
        ST_SHIFT: begin
          q_d   = ser_next;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign so   = (MSB_FIRST != 0) ? q_q[N-1] : q_q[0];
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_ulv_shift_rot_reg.sv
// Directed bench for ulv_shift_rot_reg (N=8, MSB_FIRST=1): op vectors plus serial-transfer sequences.
module tb_ulv_shift_rot_reg;
  import ulv_shift_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] op;
  logic [2:0] amt;
  logic       si;
  logic [7:0] d;
  logic [7:0] q;
  logic       so;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] ld;
    logic [2:0] op;
    logic [2:0] amt;
    logic       si;
    logic       en;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [18];

  ulv_shift_rot_reg #(.N(8), .MSB_FIRST(1)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .op    (op),
    .amt   (amt),
    .si    (si),
    .d     (d),
    .q     (q),
    .so    (so),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a transfer of dval and collects the bits on so; optionally stalls en for
  // two cycles while bit index stall_at is presented, and/or drives junk ops while busy.
  task automatic run_ser(input logic [7:0] dval, input int stall_at, input bit junk, input string tag);
    logic [7:0] sh;
    logic       so_prev;
    int         bit_i, busy_cyc, stalls, nd, cyc;
    sh = '0; bit_i = 0; busy_cyc = 0; stalls = 0; nd = 0; cyc = 0;
    en = 1'b1; op = OP_SER; d = dval; si = 1'b0; amt = 3'd0;
    tick();
    while (busy === 1'b1 && cyc < 40) begin
      busy_cyc++;
      if (done === 1'b1) nd++;
      if (junk) begin
        op  = (bit_i % 2 == 1) ? OP_LOAD : OP_ROL;
        d   = 8'hFF;
        amt = 3'd3;
      end else begin
        op = OP_HOLD;
        d  = 8'h00;
      end
      if (bit_i == stall_at && stalls < 2) begin
        en      = 1'b0;
        stalls++;
        so_prev = so;
        tick();
        chk($sformatf("%s_stall_so", tag), {31'd0, so}, {31'd0, so_prev});
        chk($sformatf("%s_stall_busy", tag), {31'd0, busy}, 32'd1);
      end else begin
        en = 1'b1;
        sh = {sh[6:0], so};
        bit_i++;
        tick();
      end
      cyc++;
    end
    en = 1'b1; op = OP_HOLD; d = 8'h00;
    chk($sformatf("%s_busy_cycles", tag), busy_cyc, 8 + stalls);
    chk($sformatf("%s_bits", tag), {24'd0, sh}, {24'd0, dval});
    chk($sformatf("%s_done_while_busy", tag), nd, 0);
    chk($sformatf("%s_done_pulse", tag), {31'd0, done}, 32'd1);
    chk($sformatf("%s_final_q", tag), {24'd0, q}, 32'h00);
    tick();
    chk($sformatf("%s_done_clear", tag), {31'd0, done}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'hB4, OP_SHL,  3'd3, 1'b1, 1'b1, 8'h00, 8'hA7};
    vecs[1]  = '{8'hB4, OP_SHR,  3'd2, 1'b0, 1'b1, 8'h00, 8'h2D};
    vecs[2]  = '{8'hB4, OP_SRA,  3'd2, 1'b0, 1'b1, 8'h00, 8'hED};
    vecs[3]  = '{8'hB4, OP_ROL,  3'd3, 1'b0, 1'b1, 8'h00, 8'hA5};
    vecs[4]  = '{8'hB4, OP_ROR,  3'd1, 1'b0, 1'b1, 8'h00, 8'h5A};
    vecs[5]  = '{8'hB4, OP_SHL,  3'd0, 1'b1, 1'b1, 8'h00, 8'hB4};
    vecs[6]  = '{8'hB4, OP_SHR,  3'd0, 1'b1, 1'b1, 8'h00, 8'hB4};
    vecs[7]  = '{8'hB4, OP_SRA,  3'd0, 1'b0, 1'b1, 8'h00, 8'hB4};
    vecs[8]  = '{8'hB4, OP_ROL,  3'd0, 1'b0, 1'b1, 8'h00, 8'hB4};
    vecs[9]  = '{8'hB4, OP_ROR,  3'd0, 1'b0, 1'b1, 8'h00, 8'hB4};
    vecs[10] = '{8'hB4, OP_HOLD, 3'd5, 1'b1, 1'b1, 8'h00, 8'hB4};
    vecs[11] = '{8'hB4, OP_SHR,  3'd2, 1'b1, 1'b1, 8'h00, 8'hED};
    vecs[12] = '{8'hB4, OP_SHL,  3'd1, 1'b0, 1'b1, 8'h00, 8'h68};
    vecs[13] = '{8'hB4, OP_ROR,  3'd7, 1'b0, 1'b1, 8'h00, 8'h69};
    vecs[14] = '{8'hB4, OP_LOAD, 3'd2, 1'b0, 1'b1, 8'h3C, 8'h3C};
    vecs[15] = '{8'hB4, OP_SHL,  3'd3, 1'b1, 1'b0, 8'h00, 8'hB4};
    vecs[16] = '{8'h4C, OP_SRA,  3'd3, 1'b0, 1'b1, 8'h00, 8'h09};
    vecs[17] = '{8'hB4, OP_SRA,  3'd7, 1'b0, 1'b1, 8'h00, 8'hFF};

    reset = 1'b0; en = 1'b0; op = OP_HOLD; amt = 3'd0; si = 1'b0; d = 8'h00;
    #1;
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_so", {31'd0, so}, 32'd0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      en = 1'b1; op = OP_LOAD; d = vecs[i].ld; amt = 3'd0; si = 1'b0;
      tick();
      en = vecs[i].en; op = vecs[i].op; amt = vecs[i].amt; si = vecs[i].si; d = vecs[i].d;
      tick();
      chk($sformatf("vec%0d_q", i), {24'd0, q}, {24'd0, vecs[i].exp});
    end
    en = 1'b1; op = OP_HOLD;

    // Asynchronous reset mid-run, checked before the next clock edge.
    op = OP_LOAD; d = 8'hB4;
    tick();
    op = OP_SER; d = 8'hC5;
    tick();
    op = OP_HOLD;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_q", {24'd0, q}, 32'h00);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    tick();
    reset = 1'b1;

    run_ser(8'hC5, -1, 1'b0, "ser_plain");
    run_ser(8'hC5, 3, 1'b0, "ser_stall");
    run_ser(8'hC5, -1, 1'b1, "ser_junk");

    // A SER op on the done cycle starts the next transfer immediately.
    en = 1'b1; op = OP_SER; d = 8'h01; si = 1'b0;
    tick();
    op = OP_HOLD; d = 8'h00;
    repeat (8) tick();
    chk("b2b_done", {31'd0, done}, 32'd1);
    op = OP_SER; d = 8'h80;
    tick();
    op = OP_HOLD; d = 8'h00;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_so", {31'd0, so}, 32'd1);
    repeat (8) tick();
    chk("b2b_done2", {31'd0, done}, 32'd1);
    tick();

    // Reset during a transfer aborts it without a done pulse.
    op = OP_SER; d = 8'hC5;
    tick();
    op = OP_HOLD; d = 8'h00;
    repeat (4) tick();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_q", {24'd0, q}, 32'h00);
    chk("abort_done", {31'd0, done}, 32'd0);
    tick();
    chk("abort_done_edge", {31'd0, done}, 32'd0);
    reset = 1'b1;
    run_ser(8'h3A, -1, 1'b0, "ser_after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ulv_shift_rot_reg.md
ULV_SHIFT_ROT_REG -- requirements
Module: ulv_shift_rot_reg

Interface
REQ-001 Parameter N, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1, serial-transmit bit order (1 = MSB first, 0 = LSB first).
REQ-003 Localparam AW = $clog2(N), shift-amount width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  clock enable; low freezes all state, including an active serial transfer.
REQ-007 op  input  3  operation select, encodings in REQ-011.
REQ-008 amt  input  AW  shift/rotate distance, 0..N-1.
REQ-009 si  input  1  serial fill bit for logical shifts and serial transmit.
REQ-010 d  input  N  parallel load / transmit data.
REQ-011 op encodings: 000 HOLD, 001 SHL, 010 SHR, 011 SRA, 100 ROL, 101 ROR, 110 LOAD, 111 SER (start serial transmit).
REQ-012 q  output  N  register contents.
REQ-013 so  output  1  serial out: q[N-1] when MSB_FIRST=1, else q[0]; combinational from register.
REQ-014 busy  output  1  high while serial transfer in progress.
REQ-015 done  output  1  one-cycle pulse after final serial bit.

Function
REQ-016 All ops SHALL take effect at the rising edge where en=1; q shows the result one cycle later.
REQ-017 HOLD: q unchanged.
REQ-018 SHL: q <= q << amt, vacated LSBs filled with si.
REQ-019 SHR: q <= q >> amt, vacated MSBs filled with si.
REQ-020 SRA: q >> amt, vacated MSBs filled with q[N-1].
REQ-021 ROL/ROR: rotate left/right by amt, no bits lost.
REQ-022 amt=0 SHALL leave q unchanged for ops 001-101.
REQ-023 LOAD: q <= d.
REQ-024 FSM states IDLE, SHIFT. SER in IDLE with en=1: q <= d, bit counter <= N, busy <= 1, state -> SHIFT.
REQ-025 In SHIFT with en=1: shift q by 1 toward so end, fill opposite end with si, counter decrements; counter reaching 0 -> IDLE, busy <= 0, done <= 1 for exactly one cycle.
REQ-026 so presents N bits on N consecutive en-qualified cycles with busy=1, first bit = d[N-1] (MSB_FIRST=1) or d[0].
REQ-027 While busy=1, op, amt and d SHALL be ignored; a SER op coinciding with done starts a new transfer.
REQ-028 en=0 in SHIFT: q, counter, busy frozen; done SHALL NOT assert while en=0.
REQ-029 Counter width $clog2(N+1); no wrap-around permitted.

Reset
REQ-030 reset low SHALL immediately, without clock: q=0, busy=0, done=0, counter=0, state=IDLE; so follows q (0).
REQ-031 Reset mid-transfer SHALL abort it; no done pulse.
REQ-032 First operation accepted on the first rising edge after reset deasserts.

Structure
REQ-033 Package ulv_shift_pkg SHALL hold typedef enum shift_op_e (REQ-011 encodings) and the FSM state enum.
REQ-034 Combinational sub-module ulv_barrel_shifter (parametrised N; inputs data, amt, op, si; output result) SHALL implement REQ-017..REQ-022; the top holds registers, FSM and counter.

Verification (N=8, MSB_FIRST=1)
REQ-035 Reset low mid-run -> q=0x00, busy=0, done=0 before next edge.
REQ-036 LOAD 0xB4, then separately: SHL amt=3 si=1 -> 0xA7; SHR amt=2 si=0 -> 0x2D; SRA amt=2 -> 0xED; ROL amt=3 -> 0xA5; ROR amt=1 -> 0x5A; amt=0 any op -> 0xB4.
REQ-037 SER d=0xC5, si=0, en=1 -> so = 1,1,0,0,0,1,0,1 over 8 busy cycles, single done pulse, final q=0x00.
REQ-038 SER d=0xC5 with en=0 for 2 cycles after bit 3 -> so holds, busy high 10 cycles, identical bit sequence, one done.
REQ-039 LOAD 0xFF / ROL issued during busy -> ignored, transfer bits unchanged.
REQ-040 SER 0xC5, reset low after bit 4 -> busy=0, q=0, no done; new SER 0x3A afterwards transmits correctly.
